// File: rtl/life_pkg.sv
// Shared Game of Life definitions: scheduler states, generation width and default grid size.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } sched_state_t;

  localparam int GEN_WIDTH  = 16;
  localparam int DEF_GRID_W = 64;
  localparam int DEF_GRID_H = 48;

endpackage

// File: rtl/counter.sv
// Wrapping up-counter with synchronous clear; carry flags the terminal count.
module counter #(
  parameter int WIDTH   = 4,
  parameter int INCR    = 1,
  parameter int RST_VAL = 0,
  parameter int MAX_VAL = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MAX_VAL - INCR);

  // carry is the terminal-count flag, independent of en, so a cascade can see it
  assign carry = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= RST_CNT;
    end else if (en) begin
      count <= carry ? RST_CNT : count + STEP;
    end
  end

endmodule

// File: rtl/life_sweep_scheduler.sv
// Sequences one Game of Life generation: raster read sweep, write re-timing, buffer swap.
//
// state | meaning
// IDLE  | waiting for run period to elapse or a step request
// SWEEP | one read strobe per cell in raster order
// DRAIN | no reads; write pipe empties for READ_LATENCY cycles
// SWAP  | one-cycle buffer swap pulse, generation count advances
module life_sweep_scheduler
  import life_pkg::*;
#(
  parameter int GRID_W       = DEF_GRID_W,
  parameter int GRID_H       = DEF_GRID_H,
  parameter int READ_LATENCY = 2,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      step,
  input  logic [PERIOD_WIDTH-1:0]   period,
  output logic                      busy,
  output logic                      rd_valid,
  output logic [$clog2(GRID_W)-1:0] rd_x,
  output logic [$clog2(GRID_H)-1:0] rd_y,
  output logic                      wr_en,
  output logic [$clog2(GRID_W)-1:0] wr_x,
  output logic [$clog2(GRID_H)-1:0] wr_y,
  output logic                      swap,
  output logic [GEN_WIDTH-1:0]      generation
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int DW = $clog2(READ_LATENCY + 1);

  sched_state_t state, state_nx;

  logic                    start;
  logic                    timer_ok;
  logic                    pending_step;
  logic [PERIOD_WIDTH-1:0] timer;
  logic [DW-1:0]           drain_cnt;
  logic [XW-1:0]           x;
  logic [YW-1:0]           y;
  logic                    x_en, y_en, x_carry, y_carry, sweep_last;
  logic [READ_LATENCY-1:0] en_pipe;
  logic [XW-1:0]           wx_pipe [READ_LATENCY];
  logic [YW-1:0]           wy_pipe [READ_LATENCY];

  // x/y stop advancing on the last cell so rd_x/rd_y hold it after the sweep
  assign sweep_last = x_carry && y_carry;
  assign x_en       = (state == SWEEP) && !sweep_last;
  assign y_en       = x_en && x_carry;

  counter #(
    .WIDTH   (XW),
    .INCR    (1),
    .RST_VAL (0),
    .MAX_VAL (GRID_W)
  ) u_x_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .en    (x_en),
    .count (x),
    .carry (x_carry)
  );

  counter #(
    .WIDTH   (YW),
    .INCR    (1),
    .RST_VAL (0),
    .MAX_VAL (GRID_H)
  ) u_y_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .en    (y_en),
    .count (y),
    .carry (y_carry)
  );

  // one extra bit so timer=all-ones plus one never wraps below period
  assign timer_ok = ({1'b0, timer} + (PERIOD_WIDTH + 1)'(1)) >= {1'b0, period};

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if ((run && timer_ok) || pending_step || (step && !run)) begin
          state_nx = SWEEP;
          start    = 1'b1;
        end
      end
      SWEEP: if (sweep_last) state_nx = DRAIN;
      DRAIN: if (drain_cnt == '0) state_nx = SWAP;
      SWAP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer        <= '1;
      pending_step <= 1'b0;
      drain_cnt    <= '0;
      generation   <= '0;
    end else begin
      if (start) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 1'b1;
      end

      if (start) begin
        pending_step <= 1'b0;
      end else if (step && !run && (state != IDLE)) begin
        pending_step <= 1'b1;
      end

      if (state == SWEEP) begin
        drain_cnt <= DW'(READ_LATENCY - 1);
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      if (state == SWAP) begin
        generation <= generation + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        wx_pipe[i] <= '0;
        wy_pipe[i] <= '0;
      end
    end else begin
      en_pipe[0] <= rd_valid;
      wx_pipe[0] <= x;
      wy_pipe[0] <= y;
      for (int i = 1; i < READ_LATENCY; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        wx_pipe[i] <= wx_pipe[i-1];
        wy_pipe[i] <= wy_pipe[i-1];
      end
    end
  end

  assign busy     = (state != IDLE);
  assign rd_valid = (state == SWEEP);
  assign swap     = (state == SWAP);
  assign rd_x     = x;
  assign rd_y     = y;
  assign wr_en    = en_pipe[READ_LATENCY-1];
  assign wr_x     = wx_pipe[READ_LATENCY-1];
  assign wr_y     = wy_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_life_sweep_scheduler.sv
// Scoreboard bench for life_sweep_scheduler on a 4x3 grid with read latency 2.
module tb_life_sweep_scheduler;

  localparam int GW = 4;
  localparam int GH = 3;
  localparam int RL = 2;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic [PW-1:0] period = '0;
  logic          busy, rd_valid, wr_en, swap;
  logic [1:0]    rd_x, wr_x;
  logic [1:0]    rd_y, wr_y;
  logic [15:0]   generation;

  life_sweep_scheduler #(
    .GRID_W       (GW),
    .GRID_H       (GH),
    .READ_LATENCY (RL),
    .PERIOD_WIDTH (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .period     (period),
    .busy       (busy),
    .rd_valid   (rd_valid),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .swap       (swap),
    .generation (generation)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int a;
    int b;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t sw_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // expected events of one generation starting its sweep at cycle s
  task automatic push_gen(input int s, input int n_rd, input int n_wr,
                          input bit do_swap, input int gen_before);
    for (int i = 0; i < n_rd; i++) rd_q.push_back('{s + i, i % GW, i / GW});
    for (int i = 0; i < n_wr; i++) wr_q.push_back('{s + RL + i, i % GW, i / GW});
    if (do_swap) sw_q.push_back('{s + GW * GH + RL, gen_before, 0});
  endtask

  task automatic goto(input int c);
    if (cyc > c) check_eq("goto_late", cyc, c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en) begin
      if (rd_valid) begin
        if (rd_q.size() == 0) check_eq("rd_unexpected", cyc, -1);
        else begin
          e = rd_q.pop_front();
          check_eq("rd_cycle", cyc, e.c);
          check_eq("rd_x", int'(rd_x), e.a);
          check_eq("rd_y", int'(rd_y), e.b);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) check_eq("wr_unexpected", cyc, -1);
        else begin
          e = wr_q.pop_front();
          check_eq("wr_cycle", cyc, e.c);
          check_eq("wr_x", int'(wr_x), e.a);
          check_eq("wr_y", int'(wr_y), e.b);
        end
      end
      if (swap) begin
        if (sw_q.size() == 0) check_eq("swap_unexpected", cyc, -1);
        else begin
          e = sw_q.pop_front();
          check_eq("swap_cycle", cyc, e.c);
          check_eq("swap_gen", int'(generation), e.a);
        end
      end
    end
  end

  task automatic check_drained(input string tag);
    check_eq({tag, "_rd_left"}, rd_q.size(), 0);
    check_eq({tag, "_wr_left"}, wr_q.size(), 0);
    check_eq({tag, "_sw_left"}, sw_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int t0;
    int t1;

    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_rd_valid", int'(rd_valid), 0);
    check_eq("rst_rd_x", int'(rd_x), 0);
    check_eq("rst_rd_y", int'(rd_y), 0);
    check_eq("rst_wr_en", int'(wr_en), 0);
    check_eq("rst_wr_x", int'(wr_x), 0);
    check_eq("rst_wr_y", int'(wr_y), 0);
    check_eq("rst_swap", int'(swap), 0);
    check_eq("rst_gen", int'(generation), 0);

    // single step, run low
    t0 = cyc + 1;
    goto(t0);
    step = 1'b1;
    push_gen(t0 + 1, GW * GH, GW * GH, 1'b1, 0);
    goto(t0 + 1);
    step = 1'b0;
    goto(t0 + 15);
    check_eq("step_busy_swap", int'(busy), 1);
    goto(t0 + 16);
    check_eq("step_busy_end", int'(busy), 0);
    check_eq("step_gen", int'(generation), 1);
    check_eq("step_rd_hold_x", int'(rd_x), GW - 1);
    check_eq("step_rd_hold_y", int'(rd_y), GH - 1);
    check_drained("step");

    // step plus two more during the sweep: exactly one extra generation
    t0 = cyc + 2;
    goto(t0);
    step = 1'b1;
    push_gen(t0 + 1, GW * GH, GW * GH, 1'b1, 1);
    push_gen(t0 + 17, GW * GH, GW * GH, 1'b1, 2);
    goto(t0 + 1);
    step = 1'b0;
    goto(t0 + 5);
    step = 1'b1;
    goto(t0 + 7);
    step = 1'b0;
    goto(t0 + 50);
    check_eq("pend_gen", int'(generation), 3);
    check_eq("pend_busy", int'(busy), 0);
    check_drained("pend");

    // free run at period 40 from reset
    reset = 1'b1;
    goto(cyc + 1);
    reset = 1'b0;
    check_eq("rst2_gen", int'(generation), 0);
    t0 = cyc + 1;
    goto(t0);
    period = PW'(40);
    run = 1'b1;
    push_gen(t0 + 1, GW * GH, GW * GH, 1'b1, 0);
    push_gen(t0 + 41, GW * GH, GW * GH, 1'b1, 1);
    push_gen(t0 + 81, GW * GH, GW * GH, 1'b1, 2);
    goto(t0 + 40);
    check_eq("p40_idle_before", int'(busy), 0);
    goto(t0 + 90);
    run = 1'b0;
    goto(t0 + 96);
    check_eq("p40_gen", int'(generation), 3);
    goto(t0 + 130);
    check_eq("p40_no_more", int'(busy), 0);
    check_drained("p40");

    // back-to-back at period 0
    t0 = cyc + 1;
    goto(t0);
    period = '0;
    run = 1'b1;
    push_gen(t0 + 1, GW * GH, GW * GH, 1'b1, 3);
    push_gen(t0 + 17, GW * GH, GW * GH, 1'b1, 4);
    push_gen(t0 + 33, GW * GH, GW * GH, 1'b1, 5);
    goto(t0 + 16);
    check_eq("b2b_idle_gap", int'(busy), 0);
    goto(t0 + 17);
    check_eq("b2b_restart", int'(busy), 1);
    goto(t0 + 34);
    run = 1'b0;
    goto(t0 + 60);
    check_eq("b2b_gen", int'(generation), 6);
    check_eq("b2b_busy", int'(busy), 0);
    check_drained("b2b");

    // reset in the middle of a stepped sweep
    t0 = cyc + 1;
    goto(t0);
    step = 1'b1;
    push_gen(t0 + 1, 7, 5, 1'b0, 0);
    goto(t0 + 1);
    step = 1'b0;
    goto(t0 + 7);
    reset = 1'b1;
    goto(t0 + 8);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_wr_en", int'(wr_en), 0);
    check_eq("mid_rst_gen", int'(generation), 0);
    check_eq("mid_rst_rd_x", int'(rd_x), 0);
    reset = 1'b0;
    goto(t0 + 30);
    check_eq("mid_rst_gen_late", int'(generation), 0);
    check_drained("mid_rst");
    t1 = cyc + 1;
    goto(t1);
    step = 1'b1;
    push_gen(t1 + 1, GW * GH, GW * GH, 1'b1, 0);
    goto(t1 + 1);
    step = 1'b0;
    goto(t1 + 16);
    check_eq("restart_gen", int'(generation), 1);
    check_drained("restart");

    // run dropped mid-generation; a step while run is high is ignored
    t0 = cyc + 1;
    goto(t0);
    period = '0;
    run = 1'b1;
    push_gen(t0 + 1, GW * GH, GW * GH, 1'b1, 1);
    goto(t0 + 2);
    step = 1'b1;
    goto(t0 + 3);
    step = 1'b0;
    goto(t0 + 5);
    run = 1'b0;
    goto(t0 + 40);
    check_eq("drop_busy", int'(busy), 0);
    check_eq("drop_gen", int'(generation), 2);
    check_drained("drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
